// File: rtl/alu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_pkg : opcodes shared with the Alu and the sequencer state encoding
// Revision: 1.0
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_A       = 3'd0,
    S_B       = 3'd1,
    S_OP      = 3'd2,
    S_CALC    = 3'd3,
    S_SEND    = 3'd4,
    S_WAIT_TX = 3'd5
  } state_t;

  function automatic logic is_busy_state(input state_t s);
    return (s == S_CALC) || (s == S_SEND) || (s == S_WAIT_TX);
  endfunction

  // States in which a partially received frame is subject to the idle timeout
  function automatic logic is_frame_state(input state_t s);
    return (s == S_B) || (s == S_OP);
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_timeout_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// frame_timeout_counter : counts enabled idle cycles, flags the last one
// Revision: 1.0
// ---------------------------------------------------------------------------
module frame_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  assign expired = enable && (count == LAST);

  // clear has priority so a byte arriving on the expiry cycle restarts the count
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || expired) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_uart_interface.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_uart_interface : gathers A/B/opcode bytes from the UART receiver,
// drives the Alu and returns its result to the UART transmitter
// Revision: 1.0
// ---------------------------------------------------------------------------
module alu_uart_interface #(
  parameter int N_BITS         = 8,
  parameter int N_OP           = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_BITS-1:0] rx_data,
  input  logic              rx_done,
  input  logic              tx_done,
  input  logic [N_BITS-1:0] alu_result,
  output logic [N_BITS-1:0] A,
  output logic [N_BITS-1:0] B,
  output logic [N_OP-1:0]   Op,
  output logic [N_BITS-1:0] tx_data,
  output logic              tx_start,
  output logic              busy,
  output logic              rx_overrun
);

  import alu_pkg::*;

  state_t state;
  state_t next_state;

  logic load_a;
  logic load_b;
  logic load_op;
  logic load_tx;
  logic byte_accept;
  logic overrun_set;
  logic timeout_enable;
  logic timeout_clear;
  logic timeout_expired;

  assign busy           = is_busy_state(state);
  assign byte_accept    = rx_done && !busy;
  assign overrun_set    = rx_done && busy;
  assign timeout_enable = is_frame_state(state);
  assign timeout_clear  = byte_accept || !timeout_enable;

  frame_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .enable (timeout_enable),
    .clear  (timeout_clear),
    .expired(timeout_expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_A;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    load_a     = 1'b0;
    load_b     = 1'b0;
    load_op    = 1'b0;
    load_tx    = 1'b0;
    case (state)
      S_A: begin
        if (rx_done) begin
          load_a     = 1'b1;
          next_state = S_B;
        end
      end
      S_B: begin
        if (rx_done) begin
          load_b     = 1'b1;
          next_state = S_OP;
        end else if (timeout_expired) begin
          next_state = S_A;
        end
      end
      S_OP: begin
        if (rx_done) begin
          load_op    = 1'b1;
          next_state = S_CALC;
        end else if (timeout_expired) begin
          next_state = S_A;
        end
      end
      S_CALC: begin
        // Op was registered on the previous edge, so alu_result is already settled
        load_tx    = 1'b1;
        next_state = S_SEND;
      end
      S_SEND: begin
        next_state = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        if (tx_done) begin
          next_state = S_A;
        end
      end
      default: begin
        next_state = S_A;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      A          <= '0;
      B          <= '0;
      Op         <= '0;
      tx_data    <= '0;
      tx_start   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      if (load_a) begin
        A <= rx_data;
      end
      if (load_b) begin
        B <= rx_data;
      end
      if (load_op) begin
        Op <= rx_data[N_OP-1:0];
      end
      if (load_tx) begin
        tx_data <= alu_result;
      end
      tx_start <= (state == S_SEND);
      if (overrun_set) begin
        rx_overrun <= 1'b1;
      end
    end
  end

  logic unused_accept;
  assign unused_accept = byte_accept;

endmodule
`default_nettype wire

// File: tb/tb_alu_uart_interface.sv
`default_nettype none
// Directed bench for alu_uart_interface with a frame-level reference model
// and a per-cycle compare process.
module tb_alu_uart_interface;

  localparam int TMO = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic       tx_done = 1'b0;
  logic [7:0] alu_result;
  logic [7:0] A;
  logic [7:0] B;
  logic [5:0] Op;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       rx_overrun;

  int n_cmp = 0;
  int n_bad = 0;
  int n_pulses = 0;

  always #5 clock = ~clock;

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h03:   return 8'($signed(a) >>> b);
      6'h02:   return a >> b;
      6'h27:   return ~(a | b);
      default: return 8'h00;
    endcase
  endfunction

  assign alu_result = alu_f(A, B, Op);

  alu_uart_interface #(
    .N_BITS(8),
    .N_OP(6),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .tx_done   (tx_done),
    .alu_result(alu_result),
    .A         (A),
    .B         (B),
    .Op        (Op),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .busy      (busy),
    .rx_overrun(rx_overrun)
  );

  // Reference model: bytes collected in the current frame, cycles since the
  // opcode was taken (-1 when not processing) and idle cycles inside a frame.
  logic [7:0] m_a, m_b, m_tx;
  logic [5:0] m_op;
  logic       m_start, m_ovr;
  int         got, since_op, idle;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_a = 0; m_b = 0; m_op = 0; m_tx = 0; m_start = 0; m_ovr = 0;
      got = 0; since_op = -1; idle = 0;
    end else begin
      m_start = 1'b0;
      if (since_op >= 0) begin
        if (rx_done) m_ovr = 1'b1;
        if (since_op >= 2 && tx_done) begin
          since_op = -1;
        end else begin
          since_op = (since_op >= 3) ? 3 : since_op + 1;
          if (since_op == 1) m_tx = alu_f(m_a, m_b, m_op);
          m_start = (since_op == 2);
        end
      end else if (rx_done) begin
        if (got == 0) m_a = rx_data;
        else if (got == 1) m_b = rx_data;
        else begin
          m_op = rx_data[5:0];
          since_op = 0;
        end
        got = (got + 1) % 3;
        idle = 0;
      end else if (got > 0) begin
        idle++;
        if (idle == TMO) begin
          got = 0;
          idle = 0;
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always begin
    @(posedge clock);
    #1;
    if (!reset) begin
      if (tx_start) n_pulses++;
      check("cyc_A", 32'(A), 32'(m_a));
      check("cyc_B", 32'(B), 32'(m_b));
      check("cyc_Op", 32'(Op), 32'(m_op));
      check("cyc_tx_data", 32'(tx_data), 32'(m_tx));
      check("cyc_tx_start", 32'(tx_start), 32'(m_start));
      check("cyc_busy", 32'(busy), 32'(since_op >= 0));
      check("cyc_rx_overrun", 32'(rx_overrun), 32'(m_ovr));
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clock);
    rx_done = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_frame_wait(input logic [7:0] a, input logic [7:0] b,
                                 input logic [7:0] op, input logic [7:0] exp);
    int n;
    send_byte(a);
    send_byte(b);
    send_byte(op);
    check("Op_loaded", 32'(Op), 32'(op[5:0]));
    n = 0;
    while (!tx_start && n < 10) begin
      @(negedge clock);
      n++;
    end
    check("start_latency", 32'(n), 32'd2);
    check("tx_data_lit", 32'(tx_data), 32'(exp));
  endtask

  task automatic complete_tx();
    tx_done = 1'b1;
    @(negedge clock);
    tx_done = 1'b0;
    check("idle_after_tx", 32'(busy), 32'd0);
  endtask

  initial begin
    int p0;
    #1;
    check("rst_A", 32'(A), 0);
    check("rst_tx_start", 32'(tx_start), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_overrun", 32'(rx_overrun), 0);
    idle_cycles(2);
    reset = 1'b0;
    idle_cycles(1);

    // ADD
    send_frame_wait(8'h05, 8'h03, 8'h20, 8'h08);
    check("add_A", 32'(A), 32'h05);
    check("add_B", 32'(B), 32'h03);
    complete_tx();

    // SUB wrap, SRA, opcode upper bits dropped
    send_frame_wait(8'h03, 8'h05, 8'h22, 8'hFE);
    complete_tx();
    send_frame_wait(8'h80, 8'h02, 8'h03, 8'hE0);
    complete_tx();
    send_frame_wait(8'h10, 8'h10, 8'hE0, 8'h20);
    check("op_trunc", 32'(Op), 32'h20);
    complete_tx();

    // Timeout abort, then a clean frame
    send_byte(8'h11);
    idle_cycles(TMO);
    check("tmo_busy", 32'(busy), 0);
    check("tmo_keep_A", 32'(A), 32'h11);
    send_frame_wait(8'h01, 8'h01, 8'h20, 8'h02);
    complete_tx();

    // Byte arriving on the expiry cycle is accepted as B
    send_byte(8'h22);
    idle_cycles(TMO - 1);
    send_byte(8'h33);
    check("expiry_B", 32'(B), 32'h33);
    send_byte(8'h20);
    idle_cycles(2);
    check("expiry_tx", 32'(tx_data), 32'h55);
    complete_tx();

    // Overrun while waiting for the transmitter
    send_frame_wait(8'h07, 8'h01, 8'h20, 8'h08);
    send_byte(8'h55);
    check("ovr_flag", 32'(rx_overrun), 1);
    check("ovr_busy", 32'(busy), 1);
    check("ovr_tx_keep", 32'(tx_data), 32'h08);
    complete_tx();
    send_frame_wait(8'h02, 8'h02, 8'h20, 8'h04);
    complete_tx();
    check("ovr_sticky", 32'(rx_overrun), 1);

    // Reset in S_OP and in S_SEND
    p0 = n_pulses;
    send_byte(8'h01);
    send_byte(8'h02);
    reset = 1'b1;
    #1;
    check("rstop_A", 32'(A), 0);
    check("rstop_tx_data", 32'(tx_data), 0);
    check("rstop_overrun", 32'(rx_overrun), 0);
    idle_cycles(2);
    reset = 1'b0;
    idle_cycles(1);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h20);
    idle_cycles(1);
    reset = 1'b1;
    #1;
    check("rstsend_tx_start", 32'(tx_start), 0);
    check("rstsend_busy", 32'(busy), 0);
    check("rstsend_tx_data", 32'(tx_data), 0);
    idle_cycles(3);
    reset = 1'b0;
    idle_cycles(2);
    check("rst_no_pulse", 32'(n_pulses - p0), 0);
    send_frame_wait(8'h0F, 8'hF0, 8'h27, 8'h00);
    complete_tx();

    // Stray tx_done in S_A, S_B, S_CALC and S_SEND; unknown opcode
    tx_done = 1'b1;
    idle_cycles(1);
    tx_done = 1'b0;
    send_byte(8'h09);
    tx_done = 1'b1;
    idle_cycles(1);
    tx_done = 1'b0;
    check("stray_A", 32'(A), 32'h09);
    send_byte(8'h06);
    send_byte(8'h3F);
    tx_done = 1'b1;
    idle_cycles(2);
    tx_done = 1'b0;
    check("stray_send_start", 32'(tx_start), 1);
    check("stray_send_busy", 32'(busy), 1);
    check("unk_op_tx", 32'(tx_data), 0);
    complete_tx();
    idle_cycles(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
